// File: rtl/tsr.sv
// UART transmit shift register. A one-deep holding register takes a parallel
// word through a valid/ready handshake. The word is then shifted out LSB-first
// as start, data, optional parity and stop bits. Bit boundaries are the rising
// edges of the baud generator's bit_tick, and every output is registered.
module tsr #(
  parameter int DATA_SIZE   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] d_i,
  input  logic                 data_valid,
  input  logic                 bit_tick,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 overrun_error,
  output logic                 transmit_line
);

  // Parity mode 3 falls back to no parity. Any stop count other than 2 is one.
  localparam bit PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit PAR_ODD = (PARITY_MODE == 2);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [3:0] LAST_DATA = 4'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 bit_tick_q;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic                 line_q, line_d;
  logic                 tick_edge;
  logic                 load;

  // bit_tick_q clears on reset. Any tick seen on the first edge after release
  // finds the holding register empty, so it cannot start a frame.
  assign tick_edge = bit_tick & ~bit_tick_q;

  // Next-state logic: host write, frame sequencing and the holding-to-shift load
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    stop_d  = stop_q;
    ready_d = ready_q;
    line_d  = line_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    load    = 1'b0;

    // A write is only accepted into an empty holding register. Otherwise the
    // write is flagged and the held word is kept.
    if (data_valid) begin
      if (ready_q) begin
        hold_d  = d_i;
        ready_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (tick_edge) begin
      case (state_q)
        S_IDLE: begin
          if (!ready_q) load = 1'b1;
        end
        S_START: begin
          line_d  = shift_q[0];
          cnt_d   = 4'd0;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (cnt_q == LAST_DATA) begin
            if (PAR_EN) begin
              line_d  = par_q;
              state_d = S_PARITY;
            end else begin
              line_d  = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 4'd1;
            line_d  = shift_q[1];
          end
        end
        S_PARITY: begin
          line_d  = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            // A waiting word starts immediately, so there is no idle bit period.
            if (!ready_q) begin
              load = 1'b1;
            end else begin
              line_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
        default: begin
          line_d  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end

    // A load takes the old holding value. A write in the same cycle was already
    // refused because ready_q was low.
    if (load) begin
      shift_d = hold_q;
      par_d   = (^hold_q) ^ PAR_ODD;
      ready_d = 1'b1;
      line_d  = 1'b0;
      state_d = S_START;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; an asynchronous reset aborts any frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= 4'd0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      bit_tick_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      line_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      bit_tick_q <= bit_tick;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      line_q     <= line_d;
    end
  end

  assign tx_ready      = ready_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign overrun_error = ovr_q;
  assign transmit_line = line_q;

endmodule

// File: tb/tb_tsr.sv
// Testbench for tsr. It runs four instances that share the clock, reset and
// bit_tick. Each instance has its own write port. The configurations are:
//   0: no parity, 1 stop    1: even parity, 1 stop
//   2: odd parity, 1 stop   3: parity mode 3 (acts as none), 2 stops
// The reference model expands each accepted word into its list of frame bits.
// It then plays the list out one bit per tick.
module tb_tsr;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_tick = 1'b0;
  logic [7:0] din [N];
  logic       dv  [N];
  logic       rdy [N];
  logic       bsy [N];
  logic       dn  [N];
  logic       ovr [N];
  logic       line[N];

  int checks = 0;
  int errors = 0;
  int done_cnt [N] = '{default: 0};

  // Reference model state
  bit         m_hfull [N];
  logic [7:0] m_hval  [N];
  bit         m_busy  [N];
  bit         m_cur   [N];
  bit         fb      [N][16];
  int         fpos    [N];
  int         flen    [N];
  int         m_done_tot [N];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      tsr #(
        .DATA_SIZE  (8),
        .PARITY_MODE(gi),
        .STOP_BITS  ((gi == 3) ? 2 : 1)
      ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .d_i          (din[gi]),
        .data_valid   (dv[gi]),
        .bit_tick     (bit_tick),
        .tx_ready     (rdy[gi]),
        .tx_busy      (bsy[gi]),
        .tx_done      (dn[gi]),
        .overrun_error(ovr[gi]),
        .transmit_line(line[gi])
      );
    end
  endgenerate

  // Count every tx_done pulse, so that stray or missing pulses show up in the totals
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) done_cnt[k] <= done_cnt[k] + ((dn[k] === 1'b1) ? 1 : 0);
  end

  task automatic check(string tag, int k, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Expand a word into its frame: start, data LSB-first, parity, stop(s)
  task automatic build_frame(int k, logic [7:0] w);
    int ones;
    int n;
    ones = 0;
    fb[k][0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb[k][1 + i] = w[i];
      if (w[i]) ones++;
    end
    n = 9;
    if (k == 1 || k == 2) begin
      fb[k][n] = ((ones % 2) == 1) ^ (k == 2);
      n++;
    end
    for (int s = 0; s < ((k == 3) ? 2 : 1); s++) begin
      fb[k][n] = 1'b1;
      n++;
    end
    flen[k] = n;
    fpos[k] = 0;
  endtask

  task automatic reset_model();
    for (int k = 0; k < N; k++) begin
      m_hfull[k] = 1'b0;
      m_hval[k]  = 8'h00;
      m_busy[k]  = 1'b0;
      m_cur[k]   = 1'b1;
      fpos[k]    = 0;
      flen[k]    = 0;
    end
  endtask

  // One bit period, followed by a comparison of every instance against the model
  task automatic do_tick(int gap);
    bit exp_done;
    @(negedge clk);
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_done = 1'b0;
      if (fpos[k] < flen[k]) begin
        m_cur[k] = fb[k][fpos[k]];
        fpos[k]++;
      end else begin
        if (m_busy[k]) begin
          exp_done = 1'b1;
          m_busy[k] = 1'b0;
          m_done_tot[k]++;
        end
        if (m_hfull[k]) begin
          build_frame(k, m_hval[k]);
          m_hfull[k] = 1'b0;
          m_busy[k]  = 1'b1;
          m_cur[k]   = fb[k][0];
          fpos[k]    = 1;
        end else begin
          m_cur[k] = 1'b1;
        end
      end
      check("line", k, 8'(line[k]), 8'(m_cur[k]));
      check("busy", k, 8'(bsy[k]), 8'(m_busy[k]));
      check("ready", k, 8'(rdy[k]), 8'(!m_hfull[k]));
      check("done", k, 8'(dn[k]), 8'(exp_done));
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_write(int k, logic [7:0] w);
    bit acc;
    acc = !m_hfull[k];
    @(negedge clk);
    din[k] = w;
    dv[k]  = 1'b1;
    @(negedge clk);
    dv[k]  = 1'b0;
    din[k] = 8'($urandom);
    if (acc) begin
      m_hfull[k] = 1'b1;
      m_hval[k]  = w;
    end
    check("overrun", k, 8'(ovr[k]), 8'(!acc));
    check("ready_after_write", k, 8'(rdy[k]), 8'h00);
    @(negedge clk);
    check("overrun_clear", k, 8'(ovr[k]), 8'h00);
    $display("write dut%0d data=%02h accepted=%0d", k, w, acc);
  endtask

  task automatic check_idle_all(string tag);
    for (int k = 0; k < N; k++) begin
      check({tag, "_line"}, k, 8'(line[k]), 8'h01);
      check({tag, "_ready"}, k, 8'(rdy[k]), 8'h01);
      check({tag, "_busy"}, k, 8'(bsy[k]), 8'h00);
      check({tag, "_done"}, k, 8'(dn[k]), 8'h00);
      check({tag, "_overrun"}, k, 8'(ovr[k]), 8'h00);
    end
  endtask

  task automatic check_done_totals();
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) check("done_total", k, 8'(done_cnt[k]), 8'(m_done_tot[k]));
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      din[k] = 8'h00;
      dv[k]  = 1'b0;
      m_done_tot[k] = 0;
    end
    reset_model();

    // Values held while reset is asserted
    repeat (3) @(negedge clk);
    check_idle_all("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55, no parity: the line alternates 0,1,... for 10 bit periods
    do_write(0, 8'h55);
    repeat (12) do_tick(1);
    $display("frame dut0 0x55 complete");

    // 0x07 with even parity (parity bit 1) and odd parity (parity bit 0)
    do_write(1, 8'h07);
    do_write(2, 8'h07);
    repeat (12) do_tick(0);
    $display("frame dut1/dut2 0x07 complete");

    // Back-to-back frames: the second start bit follows the first stop bit directly
    do_write(0, 8'hA5);
    do_tick(1);
    do_write(0, 8'h3C);
    repeat (24) do_tick(0);
    $display("back-to-back dut0 0xA5,0x3C complete");

    // Overrun: 0x22 is refused while 0x11 is held
    do_write(0, 8'h11);
    do_write(0, 8'h22);
    repeat (14) do_tick(1);
    $display("overrun dut0 complete");

    // Two stop bits, 0x00: low for 9 periods, high for 2, then done
    do_write(3, 8'h00);
    repeat (13) do_tick(0);
    $display("frame dut3 0x00 complete");
    check_done_totals();

    // Reset during data bit 3 of 0xF0 returns the line to idle without a clock edge
    do_write(0, 8'hF0);
    repeat (5) do_tick(0);
    check("mid_frame_busy", 0, 8'(bsy[0]), 8'h01);
    #2;
    reset = 1'b0;
    #1;
    check("async_line", 0, 8'(line[0]), 8'h01);
    check("async_busy", 0, 8'(bsy[0]), 8'h00);
    check("async_ready", 0, 8'(rdy[0]), 8'h01);
    reset_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) do_tick(1);
    $display("mid-frame reset dut0 complete");

    // Randomised writes and tick spacing across all instances
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0) do_write($urandom_range(0, N - 1), 8'($urandom));
      repeat ($urandom_range(0, 3)) do_tick($urandom_range(0, 2));
    end
    repeat (30) do_tick(0);
    check_done_totals();
    check_idle_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
